// File: rtl/bsg_bus_unpack_merge.sv
// Coalesces narrow right-justified writes into a full-width word plus unit mask.
// Optional BSG_BUS_UNPACK_MERGE_ALIGN_CHECK_EN: drop misaligned writes and pulse err_o.
module bsg_bus_unpack_merge #(
  parameter int unsigned width_p      = 64,
  parameter int unsigned unit_width_p = 8,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned timeout_p    = 16,
  localparam int unsigned mask_width_lp = width_p / unit_width_p,
  localparam int unsigned sel_width_lp  = (mask_width_lp > 1) ? $clog2(mask_width_lp) : 1,
  localparam int unsigned size_width_lp = $clog2(sel_width_lp + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [width_p-1:0]       data_i,
  input  logic [addr_width_p-1:0]  addr_i,
  input  logic [sel_width_lp-1:0]  sel_i,
  input  logic [size_width_lp-1:0] size_i,
  input  logic                     flush_i,
  output logic                     v_o,
  input  logic                     ready_and_i,
  output logic [width_p-1:0]       data_o,
  output logic [mask_width_lp-1:0] mask_o,
  output logic [addr_width_p-1:0]  addr_o,
  output logic                     empty_o,
  output logic                     err_o
);

  localparam int unsigned cnt_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;

  typedef enum logic [1:0] {StEmpty, StAccum, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [width_p-1:0]        data_q, data_d;
  logic [mask_width_lp-1:0]  mask_q, mask_d;
  logic [addr_width_p-1:0]   tag_q, tag_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;

  logic [width_p-1:0]        wdata, wexp;
  logic [mask_width_lp-1:0]  wmask;
  logic [sel_width_lp-1:0]   sel_eff;
  logic                      misaligned;
  logic                      drop;
  int unsigned               span, low, se;

  // Replicate the low slice across the word and build the unit mask at the aligned offset.
  always_comb begin
    wdata = '0;
    wexp  = '0;
    wmask = '0;
    if (size_i >= size_width_lp'(sel_width_lp)) span = mask_width_lp;
    else span = 1 << size_i;
    low        = span - 1;
    sel_eff    = sel_i & ~sel_width_lp'(low);
    misaligned = (sel_i & sel_width_lp'(low)) != '0;
    se         = 32'(sel_eff);
    for (int unsigned k = 0; k < mask_width_lp; k++) begin
      wmask[k] = (k >= se) && (k < se + span);
      wdata[k*unit_width_p +: unit_width_p] = data_i[(k & low)*unit_width_p +: unit_width_p];
      wexp[k*unit_width_p +: unit_width_p]  = {unit_width_p{wmask[k]}};
    end
  end

`ifdef BSG_BUS_UNPACK_MERGE_ALIGN_CHECK_EN
  assign drop  = misaligned;
  assign err_o = v_i & ready_and_o & misaligned;
`else
  assign drop  = 1'b0;
  assign err_o = 1'b0;
`endif

  logic                     tag_match, take;
  logic [width_p-1:0]       merged;
  logic [mask_width_lp-1:0] merged_mask;

  assign tag_match   = (addr_i == tag_q);
  assign merged      = (data_q & ~wexp) | (wdata & wexp);
  assign merged_mask = mask_q | wmask;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    ready_and_o = 1'b0;
    take        = 1'b0;
    unique case (state_q)
      StEmpty: begin
        ready_and_o = 1'b1;
        if (v_i && !drop) begin
          data_d  = wdata & wexp;
          mask_d  = wmask;
          tag_d   = addr_i;
          cnt_d   = '0;
          state_d = (&wmask) ? StDrain : StAccum;
        end
      end
      StAccum: begin
        ready_and_o = v_i & tag_match;
        take        = ready_and_o & ~drop;
        if (take) begin
          data_d = merged;
          mask_d = merged_mask;
          cnt_d  = '0;
        end
        // A mismatched tag stalls the write and drains the current word.
        if (flush_i || (v_i && !tag_match) || (take && (&merged_mask))) begin
          state_d = StDrain;
        end else if (!v_i && (timeout_p != 0)) begin
          cnt_d = cnt_q + cnt_width_lp'(1);
          if (cnt_d == cnt_width_lp'(timeout_p)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (ready_and_i) begin
          mask_d  = '0;
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StEmpty;
      data_q  <= '0;
      mask_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign v_o     = (state_q == StDrain);
  assign data_o  = v_o ? data_q : '0;
  assign mask_o  = v_o ? mask_q : '0;
  assign addr_o  = tag_q;
  assign empty_o = (state_q == StEmpty);

endmodule

// File: tb/tb_bsg_bus_unpack_merge.sv
// Directed bench for bsg_bus_unpack_merge: vector table plus hand-written multi-cycle cases.
module tb_bsg_bus_unpack_merge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v_i, ready_and_o, flush_i, v_o, ready_and_i, empty_o, err_o;
  logic [63:0] data_i, data_o;
  logic [31:0] addr_i, addr_o;
  logic [2:0]  sel_i;
  logic [1:0]  size_i;
  logic [7:0]  mask_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bsg_bus_unpack_merge #(
    .width_p      (64),
    .unit_width_p (8),
    .addr_width_p (32),
    .timeout_p    (4)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .data_i      (data_i),
    .addr_i      (addr_i),
    .sel_i       (sel_i),
    .size_i      (size_i),
    .flush_i     (flush_i),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .data_o      (data_o),
    .mask_o      (mask_o),
    .addr_o      (addr_o),
    .empty_o     (empty_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic        v, flush, rdy;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [1:0]  size;
    logic [63:0] data;
    logic        e_ready, e_v;
    logic [63:0] e_data;
    logic [7:0]  e_mask;
    logic [31:0] e_addr;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic flush, logic rdy, logic [31:0] addr,
                              logic [2:0] sel, logic [1:0] size, logic [63:0] data,
                              logic e_ready, logic e_v, logic [63:0] e_data,
                              logic [7:0] e_mask, logic [31:0] e_addr, logic e_empty);
    vec_t t;
    t.v = v; t.flush = flush; t.rdy = rdy; t.addr = addr; t.sel = sel; t.size = size;
    t.data = data; t.e_ready = e_ready; t.e_v = e_v; t.e_data = e_data; t.e_mask = e_mask;
    t.e_addr = e_addr; t.e_empty = e_empty;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic flush, input logic rdy, input logic [31:0] addr,
                       input logic [2:0] sel, input logic [1:0] size, input logic [63:0] data);
    v_i = v; flush_i = flush; ready_and_i = rdy; addr_i = addr; sel_i = sel; size_i = size;
    data_i = data;
  endtask

  task automatic drain_vec();
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic post_edge_check(input string tag, input logic e_v, input logic [63:0] e_data,
                                 input logic [7:0] e_mask, input logic [31:0] e_addr,
                                 input logic e_empty);
    check({tag, " v_o"}, v_o, e_v);
    check({tag, " data_o"}, data_o, e_data);
    check({tag, " mask_o"}, mask_o, e_mask);
    check({tag, " empty_o"}, empty_o, e_empty);
    if (e_v) check({tag, " addr_o"}, addr_o, e_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset v_o", v_o, 0);
    check("reset empty_o", empty_o, 1);
    check("reset mask_o", mask_o, 0);
    check("reset data_o", data_o, 0);
    check("reset err_o", err_o, 0);
    check("reset ready_and_o", ready_and_o, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Eight byte writes; the second carries junk above its byte.
    for (int k = 0; k < 8; k++) begin
      logic [63:0] d;
      d = 64'(8'((k + 1) * 17));
      if (k == 1) d = 64'hDEAD_BEEF_0000_0022;
      vecs.push_back(mk(1, 0, 0, 32'h10, 3'(k), 0, d, 1, (k == 7),
                        (k == 7) ? 64'h8877_6655_4433_2211 : 64'h0,
                        (k == 7) ? 8'hFF : 8'h00, 32'h10, 0));
    end
    drain_vec();
    // Half write then flush.
    vecs.push_back(mk(1, 0, 0, 5, 2, 1, 64'hBEEF, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h0000_0000_BEEF_0000, 8'h0C, 5, 0));
    drain_vec();
    // Tag mismatch stalls, drains, then the stalled write is taken from EMPTY.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 64'hAA, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 0, 64'hBB, 0, 1, 64'hAA, 8'h01, 1, 0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 0, 64'hBB, 0, 1, 64'hAA, 8'h01, 1, 0));
    vecs.push_back(mk(1, 0, 1, 2, 0, 0, 64'hBB, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2, 0, 0, 64'hBB, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 64'hBB, 8'h01, 2, 0));
    drain_vec();
    // Later write to the same unit wins.
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 64'h33, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 64'h55, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h5500, 8'h02, 7, 0));
    drain_vec();
    // Flush with a matching write: merge first, then drain.
    vecs.push_back(mk(1, 0, 0, 8, 1, 0, 64'h99, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8, 0, 0, 64'h66, 1, 1, 64'h9966, 8'h03, 8, 0));
    drain_vec();
    // Flush is ignored in EMPTY.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i].v, vecs[i].flush, vecs[i].rdy, vecs[i].addr, vecs[i].sel, vecs[i].size,
            vecs[i].data);
      #1;
      check({tag, " ready_and_o"}, ready_and_o, vecs[i].e_ready);
      @(posedge clk);
      #1;
      post_edge_check(tag, vecs[i].e_v, vecs[i].e_data, vecs[i].e_mask, vecs[i].e_addr,
                      vecs[i].e_empty);
    end

    // Backpressure: full word held for five cycles.
    @(negedge clk);
    drive(1, 0, 0, 32'h20, 0, 3, 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      post_edge_check($sformatf("bp%0d", c), 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 32'h20, 0);
      check($sformatf("bp%0d ready_and_o", c), ready_and_o, 0);
      @(posedge clk);
    end
    @(negedge clk);
    ready_and_i = 1'b1;
    @(posedge clk);
    #1;
    post_edge_check("bp release", 0, 0, 0, 0, 1);

    // Timeout: four idle cycles in ACCUM then drain.
    @(negedge clk);
    drive(1, 0, 0, 3, 4, 0, 64'h77);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (c < 4) post_edge_check($sformatf("timeout idle%0d", c), 0, 0, 0, 0, 0);
      else post_edge_check("timeout fire", 1, 64'h0000_0077_0000_0000, 8'h10, 3, 0);
    end
    @(negedge clk);
    ready_and_i = 1'b1;
    @(posedge clk);
    #1;
    post_edge_check("timeout drain", 0, 0, 0, 0, 1);

    // Asynchronous reset while accumulating.
    @(negedge clk);
    drive(1, 0, 0, 4, 0, 1, 64'hCCDD);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset v_o", v_o, 0);
    check("async reset empty_o", empty_o, 1);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 0, 4, 3, 0, 64'hEE);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    post_edge_check("post reset", 1, 64'hEE00_0000, 8'h08, 4, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);

`ifdef BSG_BUS_UNPACK_MERGE_ALIGN_CHECK_EN
    // Misaligned half write is handshaken, flagged and dropped.
    @(negedge clk);
    drive(1, 0, 0, 4, 0, 1, 64'h1234);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 4, 1, 1, 64'h5678);
    #1;
    check("align ready_and_o", ready_and_o, 1);
    check("align err_o pulse", err_o, 1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    check("align err_o clear", err_o, 0);
    @(posedge clk);
    #1;
    post_edge_check("align dropped", 1, 64'h1234, 8'h03, 4, 0);
`else
    // Misaligned half write is aligned down and err_o stays low.
    @(negedge clk);
    drive(1, 0, 0, 9, 1, 1, 64'h1234);
    #1;
    check("align err_o", err_o, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    post_edge_check("align down", 1, 64'h1234, 8'h03, 9, 0);
`endif
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("final empty_o", empty_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
